// File: rtl/ahb3lite_arbiter.sv
`default_nettype none
// ============================================================================
// ahb3lite_arbiter : address/data-phase arbiter for one shared AHB3-Lite bus.
// Optional macro AHB3LITE_ARB_PARK_LAST_EN keeps the last owner parked when idle.
// Revision: 1.0
// ============================================================================
module ahb3lite_arbiter #(
  parameter int MASTERS     = 4,
  parameter int SCHEME      = 1,
  parameter int PARK_MASTER = 0,
  localparam int MW         = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [MASTERS-1:0] HBUSREQ,
  input  logic [MASTERS-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  output logic [MASTERS-1:0] HGRANT,
  output logic [MW-1:0]      HMASTER,
  output logic [MW-1:0]      HMASTER_DATA,
  output logic               HMASTLOCK
);

  localparam logic [1:0]         c_IDLE       = 2'b00;
  localparam logic [1:0]         c_BUSY       = 2'b01;
  localparam logic [1:0]         c_NONSEQ     = 2'b10;
  localparam logic [2:0]         c_SINGLE     = 3'd0;
  localparam logic [2:0]         c_INCR       = 3'd1;
  localparam logic [MW-1:0]      c_PARK       = MW'(PARK_MASTER);
  localparam logic [MASTERS-1:0] c_PARK_GRANT = MASTERS'(1) << PARK_MASTER;

  logic [MASTERS-1:0] r_grant;
  logic [MW-1:0]      r_master;
  logic [MW-1:0]      r_master_data;
  logic               r_lock;
  logic [4:0]         r_cnt;
  logic [MW-1:0]      r_rr_ptr;

  logic               w_owner_req;
  logic               w_owner_lock;
  logic               w_fixed;
  logic [4:0]         w_burst_last;
  logic [4:0]         w_cnt_next;
  logic               w_lock_next;
  logic               w_arb_ok;
  logic               w_found;
  logic [MW-1:0]      w_idx;
  logic [MW-1:0]      w_winner;
  logic [MW-1:0]      w_rr_next;

  always_comb begin
    w_owner_req  = HBUSREQ[r_master];
    w_owner_lock = HLOCK[r_master];
    w_fixed      = (HBURST != c_SINGLE) && (HBURST != c_INCR);
    case (HBURST)
      3'd2, 3'd3: w_burst_last = 5'd3;
      3'd4, 3'd5: w_burst_last = 5'd7;
      3'd6, 3'd7: w_burst_last = 5'd15;
      default:    w_burst_last = 5'd0;
    endcase
    case (HTRANS)
      c_IDLE:   w_cnt_next = 5'd0;
      c_BUSY:   w_cnt_next = r_cnt;
      c_NONSEQ: w_cnt_next = w_fixed ? w_burst_last : 5'd0;
      default:  w_cnt_next = (r_cnt != 5'd0) ? (r_cnt - 5'd1) : 5'd0;
    endcase
    // A fresh locked NONSEQ always wins over a lock that is ending.
    w_lock_next = ((HTRANS == c_NONSEQ) && w_owner_lock) ||
                  (r_lock && !((HTRANS == c_IDLE) && !w_owner_lock));
    if (HTRANS == c_IDLE) begin
      w_arb_ok = 1'b1;
    end else if (HTRANS == c_BUSY) begin
      w_arb_ok = 1'b0;
    end else if (HBURST == c_SINGLE) begin
      w_arb_ok = 1'b1;
    end else if (HBURST == c_INCR) begin
      w_arb_ok = !w_owner_req;
    end else begin
      w_arb_ok = (w_cnt_next == 5'd0);
    end
    w_arb_ok = w_arb_ok && !w_lock_next;
  end

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
`ifdef AHB3LITE_ARB_PARK_LAST_EN
    w_winner = r_master;
`else
    w_winner = c_PARK;
`endif
    for (int i = 0; i < MASTERS; i++) begin
      if (SCHEME == 1) begin
        w_idx = MW'((int'(r_rr_ptr) + i) % MASTERS);
      end else begin
        w_idx = MW'(i);
      end
      if (!w_found && HBUSREQ[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    w_rr_next = MW'((int'(w_winner) + 1) % MASTERS);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant       <= c_PARK_GRANT;
      r_master      <= c_PARK;
      r_master_data <= c_PARK;
      r_lock        <= 1'b0;
      r_cnt         <= 5'd0;
      r_rr_ptr      <= c_PARK;
    end else if (HREADY) begin
      r_master_data <= r_master;
      r_cnt         <= w_cnt_next;
      r_lock        <= w_lock_next;
      if (w_arb_ok) begin
        r_master <= w_winner;
        r_grant  <= MASTERS'(1) << w_winner;
        // The pointer only advances on a real win, not when parking.
        if ((SCHEME == 1) && w_found) begin
          r_rr_ptr <= w_rr_next;
        end
      end
    end
  end

  assign HGRANT       = r_grant;
  assign HMASTER      = r_master;
  assign HMASTER_DATA = r_master_data;
  assign HMASTLOCK    = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_arbiter.sv
`default_nettype none
// Bench for ahb3lite_arbiter: vector table, hand-written corner sequences,
// and legal random traffic compared against a transfer-level reference model.
module tb_ahb3lite_arbiter;
  localparam int M    = 4;
  localparam int PARK = 0;
  localparam int MW   = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic [M-1:0]  HBUSREQ = '0;
  logic [M-1:0]  HLOCK = '0;
  logic [1:0]    HTRANS = T_IDLE;
  logic [2:0]    HBURST = B_SINGLE;
  logic          HREADY = 1'b1;
  logic [M-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic [MW-1:0] HMASTER_DATA;
  logic          HMASTLOCK;

  ahb3lite_arbiter #(.MASTERS(M), .SCHEME(1), .PARK_MASTER(PARK)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- reference model (one step per accepted transfer) -------
  typedef struct {
    int owner;
    int data;
    int rem;     // beats of the current fixed burst still to be accepted
    int ptr;
    bit locked;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic [M-1:0] req, logic [M-1:0] lck,
                                         logic [1:0] tr, logic [2:0] bu);
    mstate_t n = s;
    bit fixed = (bu >= 3'd2);
    bit ok;
    n.data = s.owner;
    if (tr == T_IDLE) n.rem = 0;
    else if (tr == T_NONSEQ) n.rem = fixed ? (4 << ((int'(bu) - 2) / 2)) - 1 : 0;
    else if (tr == T_SEQ && s.rem > 0) n.rem = s.rem - 1;
    if (tr == T_NONSEQ && lck[s.owner]) n.locked = 1'b1;
    else if (s.locked && tr == T_IDLE && !lck[s.owner]) n.locked = 1'b0;
    ok = !n.locked && (tr == T_IDLE ||
         (tr[1] && (bu == B_SINGLE || (bu == B_INCR && !req[s.owner]) || (fixed && n.rem == 0))));
    if (ok) begin
      if (req == '0) begin
`ifdef AHB3LITE_ARB_PARK_LAST_EN
        n.owner = s.owner;
`else
        n.owner = PARK;
`endif
      end else begin
        for (int k = 0; k < M; k++) begin
          int c = (s.ptr + k) % M;
          if (req[c]) begin
            n.owner = c;
            n.ptr   = (c + 1) % M;
            break;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) m <= '{PARK, PARK, 0, PARK, 1'b0};
    else if (HREADY) m <= model_next(m, HBUSREQ, HLOCK, HTRANS, HBURST);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int master, input int data, input bit lock);
    check({name, ".HMASTER"}, 32'(HMASTER), 32'(master));
    check({name, ".HGRANT"}, 32'(HGRANT), 32'(1) << master);
    check({name, ".HMASTER_DATA"}, 32'(HMASTER_DATA), 32'(data));
    check({name, ".HMASTLOCK"}, 32'(HMASTLOCK), 32'(lock));
  endtask

  task automatic drive(input logic [M-1:0] req, input logic [M-1:0] lck, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
  endtask

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  typedef struct {
    logic [M-1:0] req;
    logic [M-1:0] lck;
    logic [1:0]   tr;
    logic [2:0]   bu;
    logic         rdy;
    int           exp_m;
    int           exp_d;
    bit           exp_l;
  } vec_t;

  vec_t vt[14];

  initial begin
    // Round-robin vectors, starting from owner 0 with pointer 0.
    vt[0]  = '{4'b1010, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 1, 0, 1'b0};
    vt[1]  = '{4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 3, 1, 1'b0};
    vt[2]  = '{4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1, 3, 1'b0};
    vt[3]  = '{4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 3, 1, 1'b0};
    vt[4]  = '{4'b1110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1, 3, 1'b0};
    vt[5]  = '{4'b1110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 2, 1, 1'b0};
    vt[6]  = '{4'b1000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 3, 2, 1'b0};
    vt[7]  = '{4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b0, 3, 2, 1'b0};
    vt[8]  = '{4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 1, 3, 1'b0};
    vt[9]  = '{4'b1010, 4'b0000, T_NONSEQ, B_INCR,   1'b1, 1, 1, 1'b0};
    vt[10] = '{4'b1010, 4'b0000, T_SEQ,    B_INCR,   1'b1, 1, 1, 1'b0};
    vt[11] = '{4'b1000, 4'b0000, T_BUSY,   B_INCR,   1'b1, 1, 1, 1'b0};
    vt[12] = '{4'b1000, 4'b0000, T_SEQ,    B_INCR,   1'b1, 3, 1, 1'b0};
`ifdef AHB3LITE_ARB_PARK_LAST_EN
    vt[13] = '{4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 3, 3, 1'b0};
`else
    vt[13] = '{4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 0, 3, 1'b0};
`endif

    #2 HRESET = 1'b1;
    #1 check_state("reset", PARK, PARK, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive('0, '0, T_IDLE, B_SINGLE, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_state("park_idle", 0, 0, 1'b0);
    end

    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].lck, vt[i].tr, vt[i].bu, vt[i].rdy);
      tick();
      check_state($sformatf("rr_vec%0d", i), vt[i].exp_m, vt[i].exp_d, vt[i].exp_l);
    end

    // INCR8 by master 0, master 2 requesting from beat 2, 3-cycle stall at beat 5.
    drive(4'b0001, '0, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check("burst_grant", 32'(HMASTER), 32'd0);
    for (int beat = 1; beat <= 8; beat++) begin
      if (beat == 5) begin
        for (int s = 0; s < 3; s++) begin
          drive(4'b0101, '0, T_SEQ, B_INCR8, 1'b0);
          tick();
          check("burst_stall", 32'(HMASTER), 32'd0);
        end
      end
      drive((beat >= 2) ? 4'b0101 : 4'b0001, '0, (beat == 1) ? T_NONSEQ : T_SEQ, B_INCR8, 1'b1);
      tick();
      if (beat == 8) check_state("burst_end", 2, 0, 1'b0);
      else check("burst_hold", 32'(HMASTER), 32'd0);
    end

    // Locked sequence by master 1 while master 0 keeps requesting.
    drive(4'b0010, '0, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check("lock_grant", 32'(HMASTER), 32'd1);
    for (int t = 0; t < 3; t++) begin
      drive(4'b0011, 4'b0010, T_NONSEQ, B_SINGLE, 1'b1);
      tick();
      check_state("lock_hold", 1, 1, 1'b1);
    end
    drive(4'b0011, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check_state("lock_release", 0, 1, 1'b0);

    // Data-phase owner across a 2->0 switch with a stalled last transfer.
    drive(4'b0100, '0, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check("dp_grant", 32'(HMASTER), 32'd2);
    drive(4'b0001, '0, T_NONSEQ, B_SINGLE, 1'b1);
    tick();
    check_state("dp_switch", 0, 2, 1'b0);
    for (int s = 0; s < 2; s++) begin
      drive(4'b0001, '0, T_NONSEQ, B_SINGLE, 1'b0);
      tick();
      check_state("dp_stall", 0, 2, 1'b0);
    end
    drive(4'b0001, '0, T_NONSEQ, B_SINGLE, 1'b1);
    tick();
    check_state("dp_accept", 0, 0, 1'b0);

    // Asynchronous reset in the middle of an INCR4 burst owned by master 3.
    drive(4'b1000, '0, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check("rst_grant", 32'(HMASTER), 32'd3);
    drive(4'b1000, '0, T_NONSEQ, B_INCR4, 1'b1);
    tick();
    drive(4'b1000, '0, T_SEQ, B_INCR4, 1'b1);
    tick();
    check("rst_midburst", 32'(HMASTER), 32'd3);
    HRESET = 1'b1;
    #1 check_state("async_reset", PARK, PARK, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(4'b0100, '0, T_SEQ, B_INCR4, 1'b1);
    tick();
    check("rst_burst_abandoned", 32'(HMASTER), 32'd2);

    // Random legal traffic against the reference model.
    begin
      logic [1:0]   tr;
      logic [2:0]   bu;
      logic [M-1:0] lk;
      bit           incr_on;
      int           last_owner;
      tr = T_IDLE;
      bu = B_SINGLE;
      lk = '0;
      incr_on = 1'b0;
      last_owner = m.owner;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (HREADY === 1'b1) begin
          if (m.owner != last_owner) incr_on = 1'b0;
          if (m.rem > 0) begin
            tr = ($urandom_range(5) == 0) ? T_BUSY : T_SEQ;
          end else if (incr_on && $urandom_range(2) != 0) begin
            tr = ($urandom_range(3) == 0) ? T_BUSY : T_SEQ;
          end else begin
            tr = ($urandom_range(2) == 0) ? T_IDLE : T_NONSEQ;
            bu = 3'($urandom_range(7));
            incr_on = (tr == T_NONSEQ) && (bu == B_INCR);
          end
          lk = 4'($urandom) & 4'($urandom) & 4'($urandom);
          if (m.locked && $urandom_range(3) != 0) lk[m.owner] = 1'b1;
          last_owner = m.owner;
        end
        drive(4'($urandom), lk, tr, bu, ($urandom_range(3) != 0));
        tick();
        check_state("rand", m.owner, m.data, m.locked);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
